// File: rtl/bcd_updown_counter_n.sv
// Multi-decade BCD up/down counter with parallel load, terminal count,
// a rollover pulse and a selectable wrap/saturate policy at the limits.
module bcd_updown_counter_n #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] count_up;
  logic [W-1:0] count_dn;
  logic         all_nines;
  logic         all_zero;
  logic         load_ok;

  // Ripple a carry/borrow through the decades; at the limits the chain
  // naturally produces 0 (up from all 9s) or all 9s (down from 0).
  always_comb begin : next_value
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    count_up  = count;
    count_dn  = count;
    carry     = 1'b1;
    borrow    = 1'b1;
    d         = 4'd0;
    all_nines = 1'b1;
    all_zero  = 1'b1;
    load_ok   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          count_up[4*i +: 4] = 4'd0;
        end else begin
          count_up[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          count_dn[4*i +: 4] = 4'd9;
        end else begin
          count_dn[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
      all_nines = all_nines & (d == 4'd9);
      all_zero  = all_zero & (d == 4'd0);
      load_ok   = load_ok & (load_val[4*i +: 4] <= 4'd9);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          count <= load_val;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en) begin
        // Without WRAP the limit value is simply held.
        if (mode) begin
          if (!all_nines) begin
            count <= count_up;
          end else if (WRAP) begin
            count <= count_up;
            wrap  <= 1'b1;
          end
        end else begin
          if (!all_zero) begin
            count <= count_dn;
          end else if (WRAP) begin
            count <= count_dn;
            wrap  <= 1'b1;
          end
        end
      end
    end
  end

  assign tc = mode ? all_nines : all_zero;

endmodule
